// File: rtl/network_source_sched.sv
// network_source_sched: decodes host source opcodes into network timesteps, spikes, clears and pooled periodic stimuli
// Ports: clk, arstn (async active-low); src_valid/src_ready/src source word handshake;
//   out_ready pulses when a DEC is accepted; net_valid/net_ready timestep handshake; net_clr one-cycle clear;
//   net_inp per-input charges of the pending timestep; prdc_full all slots busy; prdc_drop sticky slot overflow.
// Define SRC_SAT_ACCUM_EN to sum same-cycle charges on one input with signed saturation.
module network_source_sched #(
    parameter int NUM_INP = 8,
    parameter int CHARGE_WIDTH = 8,
    parameter int RUN_WIDTH = 16,
    parameter int MAX_PERIOD = 255,
    parameter int MAX_NUM_PERIODS = 255,
    parameter int NUM_SLOTS = 4,
    localparam int IDX_W = NUM_INP > 1 ? $clog2(NUM_INP) : 1,
    localparam int PRD_W = $clog2(MAX_PERIOD + 1),
    localparam int NPR_W = $clog2(MAX_NUM_PERIODS + 1),
    localparam int FLD_W = IDX_W + CHARGE_WIDTH + PRD_W + NPR_W,
    localparam int SRC_WIDTH = 3 + (RUN_WIDTH > FLD_W ? RUN_WIDTH : FLD_W)
) (
    input  logic clk,
    input  logic arstn,
    input  logic src_valid,
    output logic src_ready,
    input  logic [SRC_WIDTH-1:0] src,
    output logic out_ready,
    input  logic net_ready,
    output logic net_valid,
    output logic net_clr,
    output logic signed [CHARGE_WIDTH-1:0] net_inp [NUM_INP],
    output logic prdc_full,
    output logic prdc_drop
);
    typedef enum logic [2:0] {NOP, RUN, SPK, CLR, DEC, SPK_PRDC, PRDC_STOP, RSVD} opc_t;
    localparam int T = SRC_WIDTH - 4;
    opc_t opc;
    logic step, wr, periodic, owned, found, n_drop;
    int sel;
    logic [IDX_W-1:0] f_idx;
    logic signed [CHARGE_WIDTH-1:0] f_chg;
    logic [PRD_W-1:0] f_prd;
    logic [NPR_W-1:0] f_num;
    logic [RUN_WIDTH-1:0] f_run, run_cnt, n_run;
    logic [NUM_SLOTS-1:0] s_vld, n_vld, s_inf, n_inf, fire, hit;
    logic [IDX_W-1:0] s_idx [NUM_SLOTS], n_idx [NUM_SLOTS];
    logic signed [CHARGE_WIDTH-1:0] s_chg [NUM_SLOTS], n_chg [NUM_SLOTS], n_inp [NUM_INP];
    logic [PRD_W-1:0] s_prd [NUM_SLOTS], n_prd [NUM_SLOTS], s_cnt [NUM_SLOTS], n_cnt [NUM_SLOTS];
    logic [NPR_W-1:0] s_rem [NUM_SLOTS], n_rem [NUM_SLOTS];
    assign f_idx = src[T -: IDX_W];
    assign f_chg = src[T-IDX_W -: CHARGE_WIDTH];
    assign f_prd = src[T-IDX_W-CHARGE_WIDTH -: PRD_W];
    assign f_num = src[T-IDX_W-CHARGE_WIDTH-PRD_W -: NPR_W];
    assign f_run = src[T -: RUN_WIDTH];
    assign src_ready = run_cnt <= RUN_WIDTH'(1);
    assign net_valid = run_cnt != '0;
    assign step = net_valid && net_ready;
    assign opc = src_valid && src_ready ? opc_t'(src[SRC_WIDTH-1 -: 3]) : NOP;
    assign out_ready = opc == DEC;
    assign prdc_full = &s_vld;
    assign wr = opc == SPK || opc == SPK_PRDC;
    // A zero period or a single repetition needs nothing beyond the immediate first charge
    assign periodic = f_prd != '0 && f_num != NPR_W'(1);
    always_comb begin
        n_vld = s_vld;
        n_inf = s_inf;
        n_idx = s_idx;
        n_chg = s_chg;
        n_prd = s_prd;
        n_cnt = s_cnt;
        n_rem = s_rem;
        hit = '0;
        fire = '0;
        sel = 0;
        owned = 1'b0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit[i] = s_vld[i] && s_idx[i] == f_idx;
            fire[i] = step && s_vld[i] && s_cnt[i] == s_prd[i] - PRD_W'(1);
            if (step && s_vld[i]) begin
                n_cnt[i] = fire[i] ? '0 : s_cnt[i] + PRD_W'(1);
                n_rem[i] = fire[i] && !s_inf[i] ? s_rem[i] - NPR_W'(1) : s_rem[i];
                n_vld[i] = !(fire[i] && !s_inf[i] && s_rem[i] == NPR_W'(1));
            end
            if (hit[i]) begin
                owned = 1'b1;
                sel = i;
            end
        end
        // Descending scan leaves sel on the lowest free slot
        if (!owned)
            for (int i = NUM_SLOTS - 1; i >= 0; i--)
                if (!s_vld[i]) begin
                    found = 1'b1;
                    sel = i;
                end
        if (opc == PRDC_STOP && owned)
            n_vld[sel] = 1'b0;
        if (opc == SPK_PRDC && periodic && (owned || found)) begin
            n_vld[sel] = 1'b1;
            n_idx[sel] = f_idx;
            n_chg[sel] = f_chg;
            n_prd[sel] = f_prd;
            n_cnt[sel] = '0;
            n_rem[sel] = f_num - NPR_W'(1);
            n_inf[sel] = f_num == '0;
        end
        n_drop = opc == CLR ? 1'b0 : prdc_drop || (opc == SPK_PRDC && periodic && !owned && !found);
        n_run = opc == RUN ? (f_run == '0 ? RUN_WIDTH'(1) : f_run) : step ? run_cnt - RUN_WIDTH'(1) : run_cnt;
    end
`ifdef SRC_SAT_ACCUM_EN
    localparam int SUM_W = CHARGE_WIDTH + $clog2(NUM_SLOTS + 2);
    localparam logic signed [SUM_W-1:0] S_MAX = SUM_W'((1 << (CHARGE_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] S_MIN = ~S_MAX;
    logic signed [SUM_W-1:0] sum;
    logic any;
    always_comb begin
        sum = '0;
        any = 1'b0;
        for (int j = 0; j < NUM_INP; j++) begin
            sum = '0;
            any = 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++)
                if (fire[i] && s_idx[i] == IDX_W'(j)) begin
                    sum = sum + SUM_W'(s_chg[i]);
                    any = 1'b1;
                end
            if (wr && f_idx == IDX_W'(j)) begin
                sum = sum + SUM_W'(f_chg);
                any = 1'b1;
            end
            n_inp[j] = !any ? (step || opc == CLR ? '0 : net_inp[j]) :
                       sum > S_MAX ? CHARGE_WIDTH'(S_MAX) : sum < S_MIN ? CHARGE_WIDTH'(S_MIN) : CHARGE_WIDTH'(sum);
        end
    end
`else
    // Later writes win: higher slot fires over lower ones, the op over any fire
    always_comb begin
        for (int j = 0; j < NUM_INP; j++) begin
            n_inp[j] = step || opc == CLR ? '0 : net_inp[j];
            for (int i = 0; i < NUM_SLOTS; i++)
                if (fire[i] && s_idx[i] == IDX_W'(j))
                    n_inp[j] = s_chg[i];
            if (wr && f_idx == IDX_W'(j))
                n_inp[j] = f_chg;
        end
    end
`endif
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            run_cnt <= '0;
            net_clr <= 1'b0;
            prdc_drop <= 1'b0;
            net_inp <= '{default: '0};
            s_vld <= '0;
            s_inf <= '0;
            s_idx <= '{default: '0};
            s_chg <= '{default: '0};
            s_prd <= '{default: '0};
            s_cnt <= '{default: '0};
            s_rem <= '{default: '0};
        end else begin
            run_cnt <= n_run;
            net_clr <= opc == CLR;
            prdc_drop <= n_drop;
            net_inp <= n_inp;
            s_vld <= n_vld;
            s_inf <= n_inf;
            s_idx <= n_idx;
            s_chg <= n_chg;
            s_prd <= n_prd;
            s_cnt <= n_cnt;
            s_rem <= n_rem;
        end
    end
endmodule

// File: doc/network_source_sched.md
Name: network_source_sched

Overview:
- Parametrised successor of the network input dispatcher.
- Decodes opcode words from the host source stream into network timesteps, one-shot spikes, clears and decode requests.
- Periodic stimuli are held in a pool of NUM_SLOTS shared generator slots rather than one per input, and support infinite repetition and explicit stop.
- Sits between the host-side source (UART/FIFO) and the network core.

Parameters:
NUM_INP, 8, number of network input neurons; IDX_W = max(1, $clog2(NUM_INP))
CHARGE_WIDTH, 8, signed charge width
RUN_WIDTH, 16, run-count field width
MAX_PERIOD, 255, max period; PRD_W = $clog2(MAX_PERIOD+1)
MAX_NUM_PERIODS, 255, max repeat count; NPR_W = $clog2(MAX_NUM_PERIODS+1)
NUM_SLOTS, 4, periodic generator slots (1..NUM_INP)
SRC_WIDTH, 3 + max(RUN_WIDTH, IDX_W+CHARGE_WIDTH+PRD_W+NPR_W), source word width

Ports:
clk  in  1  clock
arstn  in  1  asynchronous active-low reset
src_valid  in  1  source word valid
src_ready  out  1  block accepts a source word
src  in  SRC_WIDTH  word: [opc 3b MSB][idx][charge][period][num_periods], MSB-first packed; RUN uses [opc][run]
out_ready  out  1  DEC accepted this cycle (combinational)
net_ready  in  1  network accepts a timestep
net_valid  out  1  timestep pending
net_clr  out  1  network clear pulse
net_inp  out  NUM_INP x CHARGE_WIDTH (signed, unpacked)  per-input charge for the next timestep
prdc_full  out  1  all slots occupied
prdc_drop  out  1  sticky: SPK_PRDC rejected for lack of a slot

Behaviour:
- Opcodes: NOP=0, RUN=1, SPK=2, CLR=3, DEC=4, SPK_PRDC=5, PRDC_STOP=6; 7 is treated as NOP.
- An op executes only on a src_valid && src_ready cycle; otherwise the op is NOP.
- Reset: all outputs 0, run_counter 0, all slots free. src_ready is 1 out of reset.
- src_ready = (run_counter <= 1). net_valid = (run_counter > 0).
- RUN loads run_counter with max(run, 1). Each net_valid && net_ready cycle (a "step") decrements run_counter.
- Every step and every CLR zero all net_inp. Op-specific writes in the same cycle override that zeroing.
- SPK: net_inp[idx] <= charge.
- CLR: net_clr = 1 for exactly one cycle, then 0. Slots are retained. prdc_drop is cleared.
- DEC: out_ready = 1 in the accept cycle only. No other effect.
- SPK_PRDC:
  - First charge is always written immediately unless num_periods == 1 is the only fire needed; in that case it is still written once and no slot is kept.
  - period == 0 or num_periods == 1 → one-shot, no slot used.
  - Otherwise, if a slot already owns idx, that slot is overwritten. Else the lowest free slot is taken.
  - Slot fields on allocation: {idx, charge, period, cnt=0, rem=num_periods-1, inf=(num_periods==0)}.
  - No slot free → no slot change, first charge still written, prdc_drop <= 1.
- Per step, for each valid slot:
  - cnt == period-1 → net_inp[idx] <= charge, cnt <= 0; rem decrements unless inf.
  - Slot is freed when it fires with rem == 1 and not inf.
  - Otherwise cnt <= cnt+1.
  - Net effect: a charge is applied at timesteps 0, P, 2P, … for N total fires, or indefinitely when N == 0.
- PRDC_STOP: frees the slot owning idx (no-op if none). net_inp is unaffected.
- A slot allocated/overwritten and a step in the same cycle: the new op wins for that slot (cnt=0).
- A periodic fire and an SPK on the same idx in the same cycle: SPK wins, unless the optional feature is enabled.
- Fires to distinct inputs in the same step all apply.
- prdc_full = all slots valid (combinational from slot state).
- Reset mid-run: everything returns to reset values immediately (asynchronous).

Optional Feature:
SRC_SAT_ACCUM_EN
- Defined: all charges targeting one input in the same cycle (SPK or SPK_PRDC first fire, plus a periodic fire) are summed with signed saturation to ±(2^(CHARGE_WIDTH-1)-1 / -2^(CHARGE_WIDTH-1)).
- Undefined: last-writer priority, op > slot fire. Among slot fires to one idx, the highest slot index wins (only reachable transiently; allocation is per-idx unique).

Test Plan:
1. Reset, then RUN 0 → net_valid high for exactly 1 step; src_ready=1 throughout; net_inp all 0.
2. SPK_PRDC idx=2 charge=5 period=3 num=3, then RUN 10 with net_ready=1 → net_inp[2]=5 at steps 0,3,6 only; slot freed after step 6; prdc_full=0.
3. SPK_PRDC idx=1 charge=-4 period=2 num=0, RUN 9 → -4 at steps 0,2,4,6,8. PRDC_STOP idx=1 mid-run → no further fires.
4. NUM_SLOTS=4: five SPK_PRDC to idx 0..4 → prdc_full=1, prdc_drop=1, idx 4 fires once only. CLR → net_clr pulse 1 cycle, prdc_drop=0, slots kept.
5. net_ready held 0 during RUN 3 → run_counter and slot cnt frozen, src_ready=0. Release → exactly 3 steps.
6. With SRC_SAT_ACCUM_EN, CHARGE_WIDTH=8: periodic charge 100 and SPK 100 land on idx 0 in the same cycle → net_inp[0]=127. Without the macro → 100 from SPK.
